// File: rtl/conf_int_mac__pipe_acc.sv
// conf_int_mac__pipe_acc
// Two-stage unsigned multiply-add / accumulate unit with a valid/ready handshake
// on both sides. Stage 1 registers the masked product. Stage 2 is the output
// register, which also owns the wide accumulator and the sticky overflow flag.
module conf_int_mac__pipe_acc #(
    parameter int OP_BITWIDTH        = 16,
    parameter int DATA_PATH_BITWIDTH = 16,
    parameter int ACC_BITWIDTH       = 40,
    parameter int SAT                = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_PATH_BITWIDTH-1:0] a,
    input  logic [DATA_PATH_BITWIDTH-1:0] b,
    input  logic [DATA_PATH_BITWIDTH-1:0] c,
    input  logic                          acc_en,
    input  logic                          acc_clr,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_PATH_BITWIDTH-1:0] d,
    output logic                          ovf
);

    localparam int DW = DATA_PATH_BITWIDTH;
    localparam int PW = 2 * DW;
    localparam int SW = ACC_BITWIDTH + 1;   // one spare bit catches the accumulator carry-out

    // Reduced precision: the low (DW-OP_BITWIDTH) operand bits are dropped.
    localparam logic [DW-1:0] OP_MASK = {DW{1'b1}} << (DW - OP_BITWIDTH);

    logic                    s1_valid;
    logic [PW-1:0]           s1_p;
    logic [DW-1:0]           s1_c;
    logic                    s1_acc_en;
    logic                    s1_acc_clr;
    logic [ACC_BITWIDTH-1:0] acc;

    logic [PW-1:0]           prod;
    logic                    s2_load;
    logic [ACC_BITWIDTH-1:0] acc_base;
    logic [SW-1:0]           sum;
    logic                    over;
    logic [DW-1:0]           res;

    assign prod     = PW'(a & OP_MASK) * PW'(b & OP_MASK);
    // Stage 2 takes a new op whenever the output register is free or being drained.
    assign s2_load  = s1_valid && (!out_valid || out_ready);
    // Ready looks through both stages, so a full pipe that is draining still accepts.
    assign in_ready = !s1_valid || s2_load;

    // Stage 1: capture the masked product and the per-op controls.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid   <= 1'b0;
            s1_p       <= '0;
            s1_c       <= '0;
            s1_acc_en  <= 1'b0;
            s1_acc_clr <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_p       <= prod;
                s1_c       <= c;
                s1_acc_en  <= acc_en;
                s1_acc_clr <= acc_clr;
            end
        end
    end

    // Stage 2 arithmetic: add the addend or the accumulator, then saturate or wrap.
    always_comb begin
        acc_base = '0;
        sum      = '0;
        res      = '0;
        if (s1_acc_en && !s1_acc_clr) begin
            acc_base = acc;
        end
        if (s1_acc_en) begin
            sum = {1'b0, acc_base} + SW'(s1_p);
        end else begin
            sum = SW'(s1_p) + SW'(s1_c);
        end
        // Any bit above DW, including the accumulator carry bit, means overflow.
        over = |sum[SW-1:DW];
        if (over && (SAT != 0)) begin
            res = '1;
        end else begin
            res = sum[DW-1:0];
        end
    end

    // Stage 2 register: result, accumulator and sticky overflow move together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            d         <= '0;
            acc       <= '0;
            ovf       <= 1'b0;
        end else if (!out_valid || out_ready) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                d <= res;
                if (s1_acc_en) begin
                    acc <= sum[ACC_BITWIDTH-1:0];
                end
                if (over) begin
                    ovf <= 1'b1;
                end else if (s1_acc_en && s1_acc_clr) begin
                    ovf <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_conf_int_mac__pipe_acc.sv
// Scoreboard bench for conf_int_mac__pipe_acc. Three instances share one stimulus
// stream: full precision with saturation, 12-bit precision with saturation, and
// full precision with wrap. Each instance has its own expected-result queue and
// its own output monitor.
module tb_conf_int_mac__pipe_acc;

    localparam int DW   = 16;
    localparam int AW   = 40;
    localparam int NCFG = 3;

    typedef struct {
        logic [DW-1:0] d;
        logic          ovf;
    } exp_t;

    logic          clk       = 1'b0;
    logic          rst       = 1'b0;
    logic          in_valid  = 1'b0;
    logic          acc_en    = 1'b0;
    logic          acc_clr   = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] a = '0, b = '0, c = '0;
    logic          in_ready  [NCFG];
    logic          out_valid [NCFG];
    logic          ovf       [NCFG];
    logic [DW-1:0] d         [NCFG];

    exp_t            sbq   [NCFG][$];
    longint unsigned m_acc [NCFG];
    bit              m_ovf [NCFG];
    int              checks = 0;
    int              errors = 0;
    int              ready_mode = 0;   // 0: hold low, 1: hold high, 2: random

    conf_int_mac__pipe_acc #(.OP_BITWIDTH(16), .DATA_PATH_BITWIDTH(DW), .ACC_BITWIDTH(AW), .SAT(1)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
        .a(a), .b(b), .c(c), .acc_en(acc_en), .acc_clr(acc_clr),
        .out_valid(out_valid[0]), .out_ready(out_ready), .d(d[0]), .ovf(ovf[0]));

    conf_int_mac__pipe_acc #(.OP_BITWIDTH(12), .DATA_PATH_BITWIDTH(DW), .ACC_BITWIDTH(AW), .SAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
        .a(a), .b(b), .c(c), .acc_en(acc_en), .acc_clr(acc_clr),
        .out_valid(out_valid[1]), .out_ready(out_ready), .d(d[1]), .ovf(ovf[1]));

    conf_int_mac__pipe_acc #(.OP_BITWIDTH(16), .DATA_PATH_BITWIDTH(DW), .ACC_BITWIDTH(AW), .SAT(0)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[2]),
        .a(a), .b(b), .c(c), .acc_en(acc_en), .acc_clr(acc_clr),
        .out_valid(out_valid[2]), .out_ready(out_ready), .d(d[2]), .ovf(ovf[2]));

    always #5 clk = ~clk;

    function automatic int cfg_op(input int i);
        return (i == 1) ? 12 : 16;
    endfunction

    function automatic bit cfg_sat(input int i);
        return (i == 2) ? 1'b0 : 1'b1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Reference: each op is arithmetic on plain 64-bit integers, evaluated in acceptance order.
    task automatic model_push(input logic [DW-1:0] ta, tb, tc, input logic ten, tclr);
        longint unsigned am, bm, p, s;
        logic [DW-1:0]   mask;
        logic [DW-1:0]   dv;
        bit              over;
        for (int i = 0; i < NCFG; i++) begin
            mask = 16'hFFFF << (16 - cfg_op(i));
            am   = {48'd0, ta & mask};
            bm   = {48'd0, tb & mask};
            p    = am * bm;
            if (ten) begin
                s        = (tclr ? 64'd0 : m_acc[i]) + p;
                m_acc[i] = s & ((64'd1 << AW) - 1);
            end else begin
                s = p + {48'd0, tc};
            end
            over = (s > 64'd65535);
            dv   = (over && cfg_sat(i)) ? 16'hFFFF : s[15:0];
            if (over) m_ovf[i] = 1'b1;
            else if (ten && tclr) m_ovf[i] = 1'b0;
            sbq[i].push_back('{d: dv, ovf: m_ovf[i]});
        end
    endtask

    // out_ready driver, applied just after each rising edge.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Per-instance monitor: pop on each output transfer; d must hold while stalled.
    for (genvar g = 0; g < NCFG; g++) begin : g_mon
        logic          hold_v = 1'b0;
        logic [DW-1:0] hold_d = '0;
        exp_t          e;
        always @(negedge clk) begin
            if (hold_v) begin
                chk($sformatf("hold_valid%0d", g), 64'(out_valid[g]), 64'd1);
                chk($sformatf("hold_d%0d", g), 64'(d[g]), 64'(hold_d));
            end
            if (!rst) begin
                hold_v = 1'b0;
            end else begin
                if (out_valid[g] === 1'b1 && out_ready) begin
                    if (sbq[g].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out%0d actual=%0h required=none t=%0t", g, d[g], $time);
                    end else begin
                        e = sbq[g].pop_front();
                        chk($sformatf("d%0d", g), 64'(d[g]), 64'(e.d));
                        chk($sformatf("ovf%0d", g), 64'(ovf[g]), 64'(e.ovf));
                    end
                end
                hold_v = (out_valid[g] === 1'b1) && !out_ready;
                hold_d = d[g];
            end
        end
    end

    // Present one op (starting just after an edge) and hold it until accepted.
    task automatic issue(input logic [DW-1:0] ta, tb, tc, input logic ten, tclr);
        int n = 0;
        a = ta; b = tb; c = tc; acc_en = ten; acc_clr = tclr; in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready[0] === 1'b1) begin
                model_push(ta, tb, tc, ten, tclr);
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL issue_timeout actual=stalled required=accept t=%0t", $time);
                break;
            end
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic set_ready(input int m);
        ready_mode = m;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        if ((sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0 t=%0t", sbq[0].size(), $time);
        end
    endtask

    initial begin
        int acc_cnt;
        int k;
        logic [DW-1:0] bp_a [4];
        logic [DW-1:0] bp_b [4];
        logic [DW-1:0] bp_c [4];
        for (int i = 0; i < NCFG; i++) begin
            m_acc[i] = 0;
            m_ovf[i] = 1'b0;
        end

        // Reset state
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < NCFG; i++) begin
            chk($sformatf("rst_out_valid%0d", i), 64'(out_valid[i]), 64'd0);
            chk($sformatf("rst_d%0d", i), 64'(d[i]), 64'd0);
            chk($sformatf("rst_ovf%0d", i), 64'(ovf[i]), 64'd0);
            chk($sformatf("rst_in_ready%0d", i), 64'(in_ready[i]), 64'd1);
        end
        set_ready(1);

        // Plain multiply-add; result appears two edges after the operands are presented
        issue(16'd3, 16'd4, 16'd5, 1'b0, 1'b0);
        in_valid = 1'b0;
        chk("lat_early_valid", 64'(out_valid[0]), 64'd0);
        @(posedge clk); #1;
        chk("lat_valid", 64'(out_valid[0]), 64'd1);
        chk("lat_d", 64'(d[0]), 64'd17);
        wait_drain();

        // Reduced precision (instance 1 drops the low 4 bits)
        issue(16'h00FF, 16'h0010, 16'h0000, 1'b0, 1'b0);
        idle();
        wait_drain();

        // Back-to-back accumulation chain: 6, 26, 27
        issue(16'd2, 16'd3, 16'd0, 1'b1, 1'b1);
        issue(16'd4, 16'd5, 16'd0, 1'b1, 1'b0);
        issue(16'd1, 16'd1, 16'd0, 1'b1, 1'b0);
        idle();
        wait_drain();

        // Overflow: saturate vs wrap, sticky, then cleared by a non-overflowing acc_clr op
        issue(16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
        issue(16'd1, 16'd1, 16'd1, 1'b0, 1'b0);
        issue(16'd1, 16'd1, 16'd0, 1'b1, 1'b1);
        idle();
        wait_drain();

        // Randomized traffic with random backpressure
        set_ready(2);
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle();
            end else begin
                issue(($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255)),
                      ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255)),
                      16'($urandom),
                      1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) == 0));
            end
        end
        idle();
        set_ready(1);
        wait_drain();

        // Backpressure: 4 ops offered while out_ready is low
        set_ready(0);
        bp_a = '{16'd10, 16'd7, 16'd100, 16'd9};
        bp_b = '{16'd20, 16'd7, 16'd3,   16'd9};
        bp_c = '{16'd30, 16'd1, 16'd0,   16'd9};
        acc_cnt = 0;
        k = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            a = bp_a[k]; b = bp_b[k]; c = bp_c[k]; acc_en = 1'b0; acc_clr = 1'b0; in_valid = 1'b1;
            @(negedge clk);
            if (in_ready[0] === 1'b1) begin
                model_push(bp_a[k], bp_b[k], bp_c[k], 1'b0, 1'b0);
                k++;
                acc_cnt++;
            end
            @(posedge clk); #1;
        end
        chk("bp_accepts", 64'(acc_cnt), 64'd2);
        chk("bp_in_ready", 64'(in_ready[0]), 64'd0);
        ready_mode = 1;
        while (k < 4) begin
            issue(bp_a[k], bp_b[k], bp_c[k], 1'b0, 1'b0);
            k++;
        end
        idle();
        wait_drain();

        // Reset with two ops in flight
        set_ready(0);
        issue(16'd300, 16'd400, 16'd0, 1'b1, 1'b0);
        issue(16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
        in_valid = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < NCFG; i++) begin
            sbq[i].delete();
            m_acc[i] = 0;
            m_ovf[i] = 1'b0;
        end
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < NCFG; i++) begin
            chk($sformatf("mid_rst_out_valid%0d", i), 64'(out_valid[i]), 64'd0);
            chk($sformatf("mid_rst_ovf%0d", i), 64'(ovf[i]), 64'd0);
        end
        set_ready(1);
        // Accumulator must restart from zero: expect 6
        issue(16'd2, 16'd3, 16'd0, 1'b1, 1'b0);
        idle();
        wait_drain();
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
